// File: rtl/pipe_ctrl_pkg.sv
// Shared FSM state type and default stage numbering for the pipeline controller.
package pipe_ctrl_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } flush_state_t;

  localparam int STG_IF  = 0;
  localparam int STG_ID  = 1;
  localparam int STG_EX  = 2;
  localparam int STG_MEM = 3;
  localparam int STG_WB  = 4;

  localparam int DEF_NSTAGES = STG_WB + 1;

endpackage

// File: rtl/pipe_ctrl_if.sv
// Stall/flush request bundle and pipe-register control outputs of pipe_ctrl.
interface pipe_ctrl_if #(
  parameter int NSTAGES = 5,
  parameter int CNTW    = 16,
  parameter int SW      = $clog2(NSTAGES)
) ();

  logic [NSTAGES-1:0] stall;
  logic               fetch_valid;
  logic               flush_req;
  logic [SW-1:0]      flush_stage;

  logic [NSTAGES-1:0] wr_en;
  logic [NSTAGES-1:0] bubble;
  logic [NSTAGES-1:0] valid;
  logic               flush_pending;
  logic [CNTW-1:0]    stall_cnt;
  logic [CNTW-1:0]    flush_cnt;

  modport master (
    output stall, fetch_valid, flush_req, flush_stage,
    input  wr_en, bubble, valid, flush_pending, stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, fetch_valid, flush_req, flush_stage,
    output wr_en, bubble, valid, flush_pending, stall_cnt, flush_cnt
  );

endinterface

// File: rtl/pipe_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            inc,
  output logic [CNTW-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: stall chaining, flush bubbles with a hold state
// for targets that cannot load yet, occupancy tracking and performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int NSTAGES = DEF_NSTAGES,
  parameter int CNTW    = 16,
  parameter int SW      = $clog2(NSTAGES)
) (
  input logic        clk,
  input logic        reset_n,
  pipe_ctrl_if.slave bus
);

  localparam logic [SW-1:0] LAST_STG = SW'(NSTAGES - 1);

  flush_state_t       state;
  logic [SW-1:0]      tgt;
  logic [NSTAGES-1:0] wr_en;
  logic [NSTAGES-1:0] bubble;
  logic [NSTAGES-1:0] valid;

  logic          hold;
  logic          req_ok;
  logic          raise;
  logic          flush_active;
  logic [SW-1:0] f_tgt;
  logic          tgt_loads;

  assign hold   = (state == HOLD);
  // Stage 0 or anything past WB is not a meaningful redirect target.
  assign req_ok = bus.flush_req && (bus.flush_stage != '0) && (bus.flush_stage <= LAST_STG);
  assign raise  = req_ok && (!hold || (bus.flush_stage > tgt));

  assign flush_active = req_ok || hold;
  assign f_tgt        = raise ? bus.flush_stage : tgt;

  // NOTE: every output of this block gets a default before any conditional
  // assignment, so no path leaves a value unassigned and no latch is inferred.
  always_comb begin
    logic run;
    run    = 1'b1;
    wr_en  = '0;
    bubble = '0;
    for (int i = NSTAGES - 1; i >= 0; i--) begin
      run = run & ~bus.stall[i];
      if (flush_active && (SW'(i) < f_tgt)) begin
        wr_en[i]  = 1'b1;
        bubble[i] = 1'b1;
      end else begin
        wr_en[i]  = run;
        bubble[i] = bus.stall[i];
      end
    end
  end

  assign tgt_loads = wr_en[f_tgt];

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      tgt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (flush_active && !tgt_loads) begin
            state <= HOLD;
            tgt   <= f_tgt;
          end
        end
        HOLD: begin
          if (tgt_loads) begin
            state <= IDLE;
          end else begin
            tgt <= f_tgt;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Bubbles propagate as cleared valid bits; a stalled register keeps its bit.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid <= '0;
    end else begin
      if (wr_en[0]) begin
        valid[0] <= bus.fetch_valid & ~flush_active;
      end
      for (int i = 1; i < NSTAGES; i++) begin
        if (wr_en[i]) begin
          valid[i] <= valid[i-1] & ~bubble[i-1];
        end
      end
    end
  end

  sat_counter #(.CNTW(CNTW)) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (~wr_en[0]),
    .count   (bus.stall_cnt)
  );

  sat_counter #(.CNTW(CNTW)) u_flush_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .inc     (raise),
    .count   (bus.flush_cnt)
  );

  assign bus.wr_en         = wr_en;
  assign bus.bubble        = bubble;
  assign bus.valid         = valid;
  assign bus.flush_pending = hold;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scenario bench for pipe_ctrl: a 16-bit-counter instance and a 2-bit-counter
// instance share stimulus; expectations are queued per cycle and compared mid-cycle.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  localparam int N = 5;

  typedef struct {
    string    name;
    logic [4:0] wr;
    logic [4:0] bub;
    logic [4:0] vld;
    logic       pend;
    int         scnt;
    int         fcnt;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  pipe_ctrl_if #(.NSTAGES(N), .CNTW(16)) bus ();
  pipe_ctrl_if #(.NSTAGES(N), .CNTW(2))  bus_sat ();

  pipe_ctrl #(.NSTAGES(N), .CNTW(16)) u_dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  pipe_ctrl #(.NSTAGES(N), .CNTW(2)) u_dut_sat (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus_sat)
  );

  function automatic logic [1:0] sat2(input int v);
    return (v > 3) ? 2'd3 : 2'(v);
  endfunction

  // Apply one cycle of stimulus and queue what the DUT must show during it.
  task automatic drive(input string name, input logic rst, input logic [4:0] stl,
                       input logic fv, input logic fr, input logic [2:0] fs,
                       input logic [4:0] wr, input logic [4:0] bub, input logic [4:0] vld,
                       input logic pend, input int scnt, input int fcnt);
    exp_t e;
    reset_n             = rst;
    bus.stall           = stl;
    bus.fetch_valid     = fv;
    bus.flush_req       = fr;
    bus.flush_stage     = fs;
    bus_sat.stall       = stl;
    bus_sat.fetch_valid = fv;
    bus_sat.flush_req   = fr;
    bus_sat.flush_stage = fs;
    e.name = name; e.wr = wr; e.bub = bub; e.vld = vld;
    e.pend = pend; e.scnt = scnt; e.fcnt = fcnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard drain: one queued expectation per cycle, sampled on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      checks++;
      if (bus.wr_en !== mon_e.wr) begin
        failures++;
        $display("FAIL %s wr_en: got %b want %b", mon_e.name, bus.wr_en, mon_e.wr);
      end
      checks++;
      if (bus.bubble !== mon_e.bub) begin
        failures++;
        $display("FAIL %s bubble: got %b want %b", mon_e.name, bus.bubble, mon_e.bub);
      end
      checks++;
      if (bus.valid !== mon_e.vld) begin
        failures++;
        $display("FAIL %s valid: got %b want %b", mon_e.name, bus.valid, mon_e.vld);
      end
      checks++;
      if (bus.flush_pending !== mon_e.pend) begin
        failures++;
        $display("FAIL %s flush_pending: got %b want %b", mon_e.name, bus.flush_pending, mon_e.pend);
      end
      checks++;
      if (bus.stall_cnt !== 16'(mon_e.scnt)) begin
        failures++;
        $display("FAIL %s stall_cnt: got %0d want %0d", mon_e.name, bus.stall_cnt, mon_e.scnt);
      end
      checks++;
      if (bus.flush_cnt !== 16'(mon_e.fcnt)) begin
        failures++;
        $display("FAIL %s flush_cnt: got %0d want %0d", mon_e.name, bus.flush_cnt, mon_e.fcnt);
      end
      checks++;
      if (bus_sat.stall_cnt !== sat2(mon_e.scnt)) begin
        failures++;
        $display("FAIL %s sat stall_cnt: got %0d want %0d", mon_e.name, bus_sat.stall_cnt, sat2(mon_e.scnt));
      end
      checks++;
      if (bus_sat.flush_cnt !== sat2(mon_e.fcnt)) begin
        failures++;
        $display("FAIL %s sat flush_cnt: got %0d want %0d", mon_e.name, bus_sat.flush_cnt, sat2(mon_e.fcnt));
      end
      checks++;
      if (bus_sat.valid !== mon_e.vld) begin
        failures++;
        $display("FAIL %s sat valid: got %b want %b", mon_e.name, bus_sat.valid, mon_e.vld);
      end
    end
  end

  task automatic test_reset();
    drive("rst_idle0", 1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 1'b0, 0, 0);
    drive("rst_idle1", 1'b0, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 1'b0, 0, 0);
    drive("rst_comb",  1'b0, 5'b00100, 1'b1, 1'b0, 3'd0, 5'b11000, 5'b00100, 5'b00000, 1'b0, 0, 0);
  endtask

  task automatic test_free_flow();
    logic [4:0] vtab [6];
    vtab = '{5'b00000, 5'b00001, 5'b00011, 5'b00111, 5'b01111, 5'b11111};
    for (int i = 0; i < 6; i++) begin
      drive("free_flow", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, vtab[i], 1'b0, 0, 0);
    end
  endtask

  task automatic test_back_pressure();
    drive("bp_c1",  1'b1, 5'b01000, 1'b1, 1'b0, 3'd0, 5'b10000, 5'b01000, 5'b11111, 1'b0, 0, 0);
    drive("bp_c2",  1'b1, 5'b01000, 1'b1, 1'b0, 3'd0, 5'b10000, 5'b01000, 5'b01111, 1'b0, 1, 0);
    drive("bp_c3",  1'b1, 5'b01000, 1'b1, 1'b0, 3'd0, 5'b10000, 5'b01000, 5'b01111, 1'b0, 2, 0);
    drive("bp_rel", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b01111, 1'b0, 3, 0);
  endtask

  task automatic test_flush_immediate();
    logic [4:0] vtab [5];
    vtab = '{5'b11000, 5'b10001, 5'b00011, 5'b00111, 5'b01111};
    drive("fi_req", 1'b1, 5'b00000, 1'b1, 1'b1, 3'd2, 5'b11111, 5'b00011, 5'b11111, 1'b0, 3, 0);
    for (int i = 0; i < 5; i++) begin
      drive("fi_after", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, vtab[i], 1'b0, 3, 1);
    end
  endtask

  task automatic test_flush_held();
    logic [4:0] vtab [4];
    vtab = '{5'b10100, 5'b00100, 5'b00100, 5'b00100};
    drive("fh_req", 1'b1, 5'b00100, 1'b1, 1'b1, 3'd2, 5'b11011, 5'b00111, 5'b11111, 1'b0, 3, 1);
    for (int i = 0; i < 4; i++) begin
      drive("fh_hold", 1'b1, 5'b00100, 1'b1, 1'b0, 3'd0, 5'b11011, 5'b00111, vtab[i], 1'b1, 3, 2);
    end
    drive("fh_rel",  1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00011, 5'b00100, 1'b1, 3, 2);
    drive("fh_idle", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b01000, 1'b0, 3, 2);
  endtask

  task automatic test_merge();
    drive("mg_req2",   1'b1, 5'b00100, 1'b1, 1'b1, 3'd2, 5'b11011, 5'b00111, 5'b10001, 1'b0, 3, 2);
    drive("mg_raise4", 1'b1, 5'b10000, 1'b1, 1'b1, 3'd4, 5'b01111, 5'b11111, 5'b00000, 1'b1, 3, 3);
    drive("mg_absorb", 1'b1, 5'b10000, 1'b1, 1'b1, 3'd1, 5'b01111, 5'b11111, 5'b00000, 1'b1, 3, 4);
    drive("mg_held4",  1'b1, 5'b10000, 1'b1, 1'b0, 3'd0, 5'b01111, 5'b11111, 5'b00000, 1'b1, 3, 4);
    drive("mg_rel",    1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b01111, 5'b00000, 1'b1, 3, 4);
    drive("mg_idle",   1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 1'b0, 3, 4);
  endtask

  task automatic test_out_of_range();
    drive("oor_0",  1'b1, 5'b00000, 1'b1, 1'b1, 3'd0, 5'b11111, 5'b00000, 5'b00001, 1'b0, 3, 4);
    drive("oor_5",  1'b1, 5'b00000, 1'b1, 1'b1, 3'd5, 5'b11111, 5'b00000, 5'b00011, 1'b0, 3, 4);
    drive("oor_7",  1'b1, 5'b00000, 1'b1, 1'b1, 3'd7, 5'b11111, 5'b00000, 5'b00111, 1'b0, 3, 4);
    drive("oor_ok", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b01111, 1'b0, 3, 4);
  endtask

  task automatic test_saturation();
    logic [4:0] vtab [5];
    logic [4:0] ftab [4];
    vtab = '{5'b11111, 5'b11101, 5'b11001, 5'b10001, 5'b00001};
    ftab = '{5'b00001, 5'b00011, 5'b00111, 5'b01111};
    for (int i = 0; i < 5; i++) begin
      drive("sat_stall", 1'b1, 5'b00001, 1'b1, 1'b0, 3'd0, 5'b11110, 5'b00001, vtab[i], 1'b0, 3 + i, 4);
    end
    for (int i = 0; i < 4; i++) begin
      drive("sat_fill", 1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, ftab[i], 1'b0, 8, 4);
    end
  endtask

  task automatic test_reset_in_hold();
    drive("rh_req",   1'b1, 5'b00100, 1'b1, 1'b1, 3'd2, 5'b11011, 5'b00111, 5'b11111, 1'b0, 8, 4);
    drive("rh_reset", 1'b0, 5'b00100, 1'b1, 1'b0, 3'd0, 5'b11011, 5'b00111, 5'b10100, 1'b1, 8, 5);
    drive("rh_post",  1'b1, 5'b00100, 1'b1, 1'b0, 3'd0, 5'b11000, 5'b00100, 5'b00000, 1'b0, 0, 0);
    drive("rh_run0",  1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00000, 1'b0, 1, 0);
    drive("rh_run1",  1'b1, 5'b00000, 1'b1, 1'b0, 3'd0, 5'b11111, 5'b00000, 5'b00001, 1'b0, 1, 0);
  endtask

  initial begin
    bus.stall           = '0;
    bus.fetch_valid     = 1'b0;
    bus.flush_req       = 1'b0;
    bus.flush_stage     = '0;
    bus_sat.stall       = '0;
    bus_sat.fetch_valid = 1'b0;
    bus_sat.flush_req   = 1'b0;
    bus_sat.flush_stage = '0;
    @(posedge clk);
    #1;
    test_reset();
    test_free_flow();
    test_back_pressure();
    test_flush_immediate();
    test_flush_held();
    test_merge();
    test_out_of_range();
    test_saturation();
    test_reset_in_hold();
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter NSTAGES, default 5, number of pipeline stages; stage 0 = IF, stage NSTAGES-1 = WB; legal range 3..16.
REQ-002 Parameter CNTW, default 16, width of each performance counter.
REQ-003 Parameter SW, default $clog2(NSTAGES), width of the stage index.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset_n  in  1  reset, synchronous and active-low.
REQ-006 stall  in  NSTAGES  per-stage stall request, bit i = stage i cannot complete this cycle.
REQ-007 fetch_valid  in  1  IF is presenting a real instruction this cycle.
REQ-008 flush_req  in  1  redirect request; all stages with index < flush_stage are to be emptied.
REQ-009 flush_stage  in  SW  target of the flush request; legal values 1..NSTAGES-1.
REQ-010 wr_en  out  NSTAGES  bit i = pipe register of stage i loads this cycle.
REQ-011 bubble  out  NSTAGES  bit i = stage i passes a bubble downstream this cycle.
REQ-012 valid  out  NSTAGES  registered occupancy, bit i = pipe register i holds a real instruction.
REQ-013 flush_pending  out  1  a flush is accepted but not yet delivered to its target stage.
REQ-014 stall_cnt  out  CNTW  saturating count of cycles with wr_en[0]=0.
REQ-015 flush_cnt  out  CNTW  saturating count of accepted flushes.

Function
REQ-016 Shall compute wr_en combinationally: wr_en[N-1] = ~stall[N-1]; wr_en[i] = wr_en[i+1] & ~stall[i] for i < N-1.
REQ-017 With no active flush, bubble[i] shall equal stall[i].
REQ-018 Active flush target F shall be flush_stage when flush_req=1, else the held target when flush_pending=1; on both, the larger index wins.
REQ-019 With an active flush at target F: bubble[i]=1 for all i<F; wr_en[i]=1 for all 0<i<F regardless of stall; wr_en[0]=1.
REQ-020 With an active flush, wr_en[F] and higher shall keep the chaining of REQ-016; the instruction in stage F shall not be overwritten early.
REQ-021 valid update on wr_en[i]=1: valid[0] <= fetch_valid & ~flush_active; valid[i] <= valid[i-1] & ~bubble[i-1] for i>0.
REQ-022 valid[i] shall hold when wr_en[i]=0.
REQ-023 FSM states IDLE and HOLD; registered target register tgt (SW bits).
REQ-024 IDLE -> HOLD when a flush is active and wr_en[F]=0; tgt <= F.
REQ-025 In IDLE, a flush with wr_en[F]=1 shall complete the same cycle; no state change.
REQ-026 HOLD -> IDLE on the first cycle wr_en[tgt]=1 (tgt loads the bubble); a new flush_req in HOLD with a larger index shall replace tgt; a smaller or equal index shall be absorbed.
REQ-027 flush_pending shall be 1 exactly in HOLD.
REQ-028 flush_cnt shall increment once per flush_req cycle in IDLE and once per flush_req cycle in HOLD that raises tgt; absorbed requests shall not count.
REQ-029 Both counters shall saturate at all-ones and never wrap.
REQ-030 Out-of-range flush_stage (0 or >= NSTAGES) shall be ignored; no counter change.

Reset
REQ-031 While reset_n=0 at the clock edge: valid=0, state=IDLE, tgt=0, stall_cnt=0, flush_cnt=0.
REQ-032 Reset asserted mid-HOLD shall drop the pending flush with no further bubbles.
REQ-033 Combinational outputs shall follow REQ-016/017 during reset, since the state is cleared.

Structure
REQ-034 A shared package pipe_ctrl_pkg shall hold the FSM state enum and the default stage constants STG_IF=0, STG_ID=1, STG_EX=2, STG_MEM=3, STG_WB=4.
REQ-035 One sub-module sat_counter (parameter CNTW; ports clk, reset_n, inc, count) shall be instantiated twice.

Verification
REQ-036 Free flow (N=5): stall=0, fetch_valid=1 for 6 cycles -> wr_en=5'b11111 each cycle; valid=5'b11111 after cycle 5.
REQ-037 Back-pressure: stall[3]=1 for 3 cycles -> wr_en=5'b10000, bubble[3]=1; valid[4] clears one cycle later; stall_cnt=3.
REQ-038 Immediate flush: flush_req=1, flush_stage=2, no stalls -> bubble[1:0]=2'b11, wr_en=5'b11111; next cycle valid[2:1]=2'b00; flush_cnt=1; flush_pending stays 0.
REQ-039 Held flush: flush_stage=2 with stall[2]=1 for 4 cycles -> flush_pending=1 for 4 cycles, bubble[1:0]=2'b11 throughout; on release valid[2]=0 next cycle, then IDLE.
REQ-040 Merge: in HOLD with tgt=2, flush_req with flush_stage=4 -> tgt=4, flush_cnt +1; then flush_stage=1 -> absorbed, flush_cnt unchanged.
REQ-041 Saturation/reset: CNTW=2, 5 stalled cycles -> stall_cnt=3; reset_n=0 in HOLD -> next cycle flush_pending=0, valid=0, counters=0.
